// File: rtl/color_grid_manager.sv
// color_grid_manager: configurable region-colour grid for a VGA pixel path with serial geometry recompute
module color_grid_manager #(
  parameter int MAX_COLS = 4,
  parameter int MAX_ROWS = 4,
  parameter int COLOR_WIDTH = 12,
  parameter int COUNTER_WIDTH = 11,
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 16,
  parameter int ADDR_RES = 0,
  parameter int ADDR_COLOR = 1,
  parameter int ADDR_SPLIT = 2,
  parameter logic [COLOR_WIDTH-1:0] DBG0 = 12'hF00,
  parameter logic [COLOR_WIDTH-1:0] DBG1 = 12'h0F0,
  parameter logic [COLOR_WIDTH-1:0] DBG2 = 12'h00F,
  parameter logic [COLOR_WIDTH-1:0] DBG3 = 12'hFFF
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [C_ADDR_WIDTH-1:0]  C_Addr,
  input  logic [C_DATA_WIDTH-1:0]  C_Data,
  input  logic                     C_Valid,
  output logic                     C_Rdy,
  input  logic                     VGA_Debugg,
  input  logic                     Counter_X_Valid,
  input  logic                     Counter_Y_Valid,
  input  logic [COUNTER_WIDTH-1:0] Counter_X,
  input  logic [COUNTER_WIDTH-1:0] Counter_Y,
  output logic [COLOR_WIDTH-1:0]   Data_VGA,
  output logic [COUNTER_WIDTH-1:0] H_Active,
  output logic [COUNTER_WIDTH-1:0] V_Active,
  output logic [COUNTER_WIDTH-1:0] H_Total,
  output logic [COUNTER_WIDTH-1:0] V_Total,
  output logic [1:0]               VGA_Notification,
  output logic                     VGA_Notification_Valid
);
  localparam int CW = COUNTER_WIDTH;
  localparam int M = MAX_COLS > MAX_ROWS ? MAX_COLS : MAX_ROWS;
  localparam int N = MAX_COLS * MAX_ROWS;
  typedef enum logic [2:0] {IDLE, DIV_X, DIV_Y, ACCUM, COMMIT} state_t;
  state_t state;
  logic [COLOR_WIDTH-1:0] colors [0:15];
  logic [CW-1:0] bx [0:M-1];
  logic [CW-1:0] by [0:M-1];
  logic [CW-1:0] pbx [0:M-1];
  logic [CW-1:0] pby [0:M-1];
  logic [3:0] cols, rows, p_c, p_r;
  logic [CW-1:0] p_ha, p_va, p_ht, p_vt;
  logic [1:0] p_code;
  logic [CW-1:0] dv, rem, step_x, step_y, acc_x, acc_y, cnt;
  logic [CW-2:0] q;
  logic is_res, is_col, is_spl, res_ok, spl_ok, ge;
  logic [1:0] rc;
  logic [3:0] sc, sr, dsr;
  logic [CW-1:0] ra, rv, rht, rvt, nrem, ax_n, ay_n;
  logic [CW:0] t, dd;
  logic [2:0] col, row;
  logic [3:0] idx;
  logic dc, dr;
  logic [COLOR_WIDTH-1:0] pix;
  assign C_Rdy = state == IDLE;
  always_comb begin
    is_res = C_Addr == C_ADDR_WIDTH'(ADDR_RES);
    is_col = C_Addr == C_ADDR_WIDTH'(ADDR_COLOR);
    is_spl = C_Addr == C_ADDR_WIDTH'(ADDR_SPLIT);
    rc = C_Data[1:0];
    sc = C_Data[3:0];
    sr = C_Data[7:4];
    res_ok = rc != 2'd3;
    spl_ok = sc != 0 && sc <= 4'(MAX_COLS) && sr != 0 && sr <= 4'(MAX_ROWS);
    ra  = rc == 2'd0 ? CW'(640) : rc == 2'd1 ? CW'(800)  : CW'(1024);
    rv  = rc == 2'd0 ? CW'(480) : rc == 2'd1 ? CW'(600)  : CW'(768);
    rht = rc == 2'd0 ? CW'(800) : rc == 2'd1 ? CW'(1056) : CW'(1344);
    rvt = rc == 2'd0 ? CW'(525) : rc == 2'd1 ? CW'(628)  : CW'(806);
    dsr = state == DIV_X ? p_c : p_r;
    t = {rem, dv[CW-1]};
    dd = (CW+1)'(dsr);
    ge = t >= dd;
    nrem = ge ? CW'(t - dd) : t[CW-1:0];
    ax_n = acc_x + step_x;
    ay_n = acc_y + step_y;
  end
  // pixel path: region index is the number of committed boundaries already passed
  always_comb begin
    col = 3'd0;
    row = 3'd0;
    for (int i = 0; i < MAX_COLS - 1; i++) col = col + 3'(bx[i] <= Counter_X);
    for (int i = 0; i < MAX_ROWS - 1; i++) row = row + 3'(by[i] <= Counter_Y);
    idx = 4'(row * MAX_COLS + col);
    dc = Counter_X >= (H_Active >> 1);
    dr = Counter_Y >= (V_Active >> 1);
    pix = VGA_Debugg ? (dr ? (dc ? DBG3 : DBG2) : (dc ? DBG1 : DBG0)) : colors[idx];
  end
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) Data_VGA <= '0;
    else Data_VGA <= (Counter_X_Valid && Counter_Y_Valid) ? pix : '0;
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      state <= IDLE;
      VGA_Notification <= 2'd0;
      VGA_Notification_Valid <= 1'b0;
      for (int i = 0; i < 16; i++) colors[i] <= '0;
      for (int i = 0; i < M; i++) begin
        bx[i] <= CW'(640);
        by[i] <= CW'(480);
        pbx[i] <= CW'(640);
        pby[i] <= CW'(480);
      end
      H_Active <= CW'(640);
      V_Active <= CW'(480);
      H_Total <= CW'(800);
      V_Total <= CW'(525);
      cols <= 4'd1;
      rows <= 4'd1;
      p_c <= 4'd1;
      p_r <= 4'd1;
      p_ha <= CW'(640);
      p_va <= CW'(480);
      p_ht <= CW'(800);
      p_vt <= CW'(525);
      p_code <= 2'd0;
      dv <= '0;
      rem <= '0;
      q <= '0;
      step_x <= '0;
      step_y <= '0;
      acc_x <= '0;
      acc_y <= '0;
      cnt <= '0;
    end else begin
      VGA_Notification <= 2'd0;
      VGA_Notification_Valid <= 1'b0;
      case (state)
        IDLE: if (C_Valid) begin
          if (is_col && {1'b0, C_Data[15:12]} < 5'(N)) colors[C_Data[15:12]] <= COLOR_WIDTH'(C_Data[11:0]);
          if ((is_res && !res_ok) || (is_spl && !spl_ok)) begin
            VGA_Notification <= 2'd3;
            VGA_Notification_Valid <= 1'b1;
          end else if (is_res || is_spl) begin
            p_ha <= is_res ? ra : H_Active;
            p_va <= is_res ? rv : V_Active;
            p_ht <= is_res ? rht : H_Total;
            p_vt <= is_res ? rvt : V_Total;
            p_c <= is_spl ? sc : cols;
            p_r <= is_spl ? sr : rows;
            p_code <= is_res ? 2'd1 : 2'd2;
            dv <= is_res ? ra : H_Active;
            rem <= '0;
            cnt <= '0;
            state <= DIV_X;
          end
        end
        DIV_X, DIV_Y: begin
          rem <= nrem;
          dv <= dv << 1;
          q <= {q[CW-3:0], ge};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(CW - 1)) begin
            cnt <= '0;
            rem <= '0;
            if (state == DIV_X) begin
              step_x <= {q, ge};
              dv <= p_va;
              state <= DIV_Y;
            end else begin
              step_y <= {q, ge};
              acc_x <= '0;
              acc_y <= '0;
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          acc_x <= ax_n;
          acc_y <= ay_n;
          cnt <= cnt + 1'b1;
          // entry i holds boundary k=i+1; boundaries past the split sit at the active edge
          for (int i = 0; i < M; i++)
            if (cnt == CW'(i)) begin
              pbx[i] <= CW'(i + 1) < CW'(p_c) ? ax_n : p_ha;
              pby[i] <= CW'(i + 1) < CW'(p_r) ? ay_n : p_va;
            end
          if (cnt == CW'(M - 1)) state <= COMMIT;
        end
        COMMIT: begin
          for (int i = 0; i < M; i++) begin
            bx[i] <= pbx[i];
            by[i] <= pby[i];
          end
          H_Active <= p_ha;
          V_Active <= p_va;
          H_Total <= p_ht;
          V_Total <= p_vt;
          cols <= p_c;
          rows <= p_r;
          VGA_Notification <= p_code;
          VGA_Notification_Valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/color_grid_manager.md
COLOR_GRID_MANAGER -- requirements
Module: color_grid_manager

Interface
REQ-001 Parameter MAX_COLS, default 4, meaning max region columns (1..4).
REQ-002 Parameter MAX_ROWS, default 4, meaning max region rows (1..4).
REQ-003 Parameter COLOR_WIDTH, default 12, meaning RGB444 pixel width.
REQ-004 Parameter COUNTER_WIDTH, default 11, meaning pixel counter and geometry width.
REQ-005 Parameters C_ADDR_WIDTH, default 4, and C_DATA_WIDTH, default 16, meaning config bus widths.
REQ-006 Parameters ADDR_RES, ADDR_COLOR and ADDR_SPLIT, defaults 0, 1 and 2, meaning config register addresses.
REQ-007 Parameters DBG0..DBG3, defaults 12'hF00, 12'h0F0, 12'h00F and 12'hFFF, meaning debug quadrant colours.
REQ-008 Clk  in  1  system clock; all state on rising edge.
REQ-009 Rst  in  1  asynchronous, active-low reset.
REQ-010 C_Addr  in  C_ADDR_WIDTH  config register address.
REQ-011 C_Data  in  C_DATA_WIDTH  config write data.
REQ-012 C_Valid  in  1  config write strobe.
REQ-013 C_Rdy  out  1  block able to accept config write.
REQ-014 VGA_Debugg  in  1  force debug 2x2 pattern.
REQ-015 Counter_X_Valid, Counter_Y_Valid  in  1 each  counters inside active area.
REQ-016 Counter_X, Counter_Y  in  COUNTER_WIDTH each  current pixel position.
REQ-017 Data_VGA  out  COLOR_WIDTH  registered pixel colour.
REQ-018 H_Active, V_Active, H_Total, V_Total  out  COUNTER_WIDTH each  committed timing.
REQ-019 VGA_Notification  out  2  event code: 1 resolution, 2 split, 3 rejected.
REQ-020 VGA_Notification_Valid  out  1  one-cycle notification strobe.

Function
REQ-021 A write SHALL be accepted only on a cycle with C_Valid=1 and C_Rdy=1; writes to any other address SHALL be ignored.
REQ-022 ADDR_COLOR write SHALL store C_Data[11:0] into region C_Data[15:12] (index = row*MAX_COLS+col), effective next cycle, with C_Rdy staying 1.
REQ-023 ADDR_RES write SHALL use C_Data[1:0] to select active/total: 0=640x480/800x525, 1=800x600/1056x628, 2=1024x768/1344x806; code 3 SHALL be rejected.
REQ-024 ADDR_SPLIT write SHALL use C_Data[3:0]=cols and C_Data[7:4]=rows; 0 or above MAX SHALL be rejected.
REQ-025 A rejected write SHALL change no state and SHALL pulse notification code 3 on the next cycle.
REQ-026 FSM states SHALL be IDLE -> DIV_X (COUNTER_WIDTH cycles) -> DIV_Y (COUNTER_WIDTH cycles) -> ACCUM (max(MAX_COLS,MAX_ROWS) cycles) -> COMMIT (1 cycle) -> IDLE; only an accepted valid RES/SPLIT write SHALL leave IDLE.
REQ-027 C_Rdy SHALL be 1 only in IDLE; busy latency SHALL be 2*COUNTER_WIDTH+max(MAX_COLS,MAX_ROWS)+1 cycles.
REQ-028 DIV_X/DIV_Y SHALL compute step = floor(active/count) with a bit-serial restoring divider (no combinational divide).
REQ-029 ACCUM SHALL build boundary_k = k*step by repeated addition for k=1..count-1; unused boundaries SHALL equal the active size.
REQ-030 The last column/row SHALL absorb the remainder pixels.
REQ-031 During recompute, the pixel path SHALL use old committed geometry; COMMIT SHALL update timing outputs, boundaries and split atomically.
REQ-032 The notification SHALL pulse for exactly 1 cycle after COMMIT, with code 1 (RES) or 2 (SPLIT), coincident with C_Rdy returning to 1.
REQ-033 Column SHALL equal the count of committed column boundaries <= Counter_X; row SHALL be computed the same way from Counter_Y.
REQ-034 Data_VGA SHALL be 1-cycle latency: with both counter valids =1, it takes the region colour, else 0.
REQ-035 With VGA_Debugg=1, the pixel path SHALL use a 2x2 split at H_Active>>1 and V_Active>>1 with DBG0 (UL), DBG1 (UR), DBG2 (LL) and DBG3 (LR); config bus processing SHALL continue unaffected.
REQ-036 A colour write to the region being displayed SHALL appear on Data_VGA no earlier than 2 cycles after acceptance.

Reset
REQ-037 Rst low SHALL immediately force IDLE, C_Rdy=1, Data_VGA=0, VGA_Notification=0 and VGA_Notification_Valid=0, all region colours 0, and 640x480/800x525 with 1x1 split and boundaries=active size.
REQ-038 Reset mid-recompute SHALL abandon the computation without notification; no notification SHALL follow reset release.

Verification
REQ-039 Reset, both valids=1, X=100, Y=100 -> Data_VGA=0, C_Rdy=1, H_Active=640.
REQ-040 SPLIT write 0x22, then colours 0x0F00/0x1F0F/0x40FF/0x5123 -> X=320,Y=240 gives 0x123, X=319,Y=239 gives 0xF00; C_Rdy low 27 cycles; code 2 pulse.
REQ-041 RES write 1 then SPLIT 0x13 -> boundaries 266 and 532, X=799 maps to col 2, H_Total=1056, two notifications (1 then 2).
REQ-042 SPLIT write 0x05 or RES write 3 -> code 3 pulse one cycle later, C_Rdy stays 1, geometry unchanged.
REQ-043 VGA_Debugg=1 at 640x480: X=400,Y=100 gives 0x0F0; a colour write during debug is stored and appears after VGA_Debugg=0.
REQ-044 Rst asserted at cycle 10 of a recompute -> C_Rdy=1 at once, 640x480 restored, no notification within 40 cycles.
